// File: rtl/rotate_arb_pkg.sv
// rotate_arb_pkg: shared types and default sizes for rotate_arbiter
package rotate_arb_pkg;
  typedef enum logic {EMPTY, FULL} rot_arb_state_t;
  localparam int ROT_ARB_N_DEF = 3;
  localparam int ROT_ARB_R_DEF = 4;
endpackage

// File: rtl/param_left_shifter.sv
// param_left_shifter: combinational left rotate of a 2**N-bit word by sel
module param_left_shifter #(
  parameter int N = 3
) (
  input  logic [2**N-1:0] data,
  input  logic [N-1:0]    sel,
  output logic [2**N-1:0] rot
);
  logic [2*(2**N)-1:0] dbl;
  assign dbl = {data, data} << sel;
  assign rot = dbl[2*(2**N)-1:2**N];
endmodule

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin pick, first req scanning up from ptr+1
module rr_picker #(
  parameter int R = 4,
  localparam int ID_W = $clog2(R)
) (
  input  logic [R-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  input  logic            en,
  output logic [R-1:0]    grant,
  output logic [ID_W-1:0] idx
);
  logic hit;
  always_comb begin
    idx = '0;
    hit = 1'b0;
    for (int k = R; k >= 1; k--) begin
      if (req[(int'(ptr) + k) % R]) begin
        idx = ID_W'((int'(ptr) + k) % R);
        hit = 1'b1;
      end
    end
    grant = (en && hit) ? R'(1) << idx : '0;
  end
endmodule

// File: rtl/rotate_arbiter.sv
// rotate_arbiter: round-robin sharing of one rotator among R requesters; ROT_ARB_DIR_EN honours req_dir
module rotate_arbiter
  import rotate_arb_pkg::*;
#(
  parameter int N = ROT_ARB_N_DEF,
  parameter int R = ROT_ARB_R_DEF,
  localparam int W = 2**N,
  localparam int ID_W = $clog2(R)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [R-1:0]        req_valid,
  output logic [R-1:0]        req_ready,
  input  logic [R-1:0][W-1:0] req_data,
  input  logic [R-1:0][N-1:0] req_amt,
  input  logic [R-1:0]        req_dir,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [W-1:0]        out_data,
  output logic [ID_W-1:0]     out_id,
  output logic                busy
);
  rot_arb_state_t state, state_n;
  logic [ID_W-1:0] ptr, idx;
  logic can_accept, xfer;
  logic [N-1:0] amt;
  logic [W-1:0] rot;
  assign can_accept = (state == EMPTY) || out_ready;
  rr_picker #(.R(R)) u_pick (
    .req(req_valid), .ptr(ptr), .en(can_accept), .grant(req_ready), .idx(idx)
  );
  assign xfer = |req_ready;
`ifdef ROT_ARB_DIR_EN
  // right rotate by a == left rotate by -a mod 2**N
  assign amt = req_dir[idx] ? -req_amt[idx] : req_amt[idx];
`else
  logic unused_dir;
  assign unused_dir = ^req_dir;
  assign amt = req_amt[idx];
`endif
  param_left_shifter #(.N(N)) u_rot (.data(req_data[idx]), .sel(amt), .rot(rot));
  always_comb state_n = xfer ? FULL : out_ready ? EMPTY : state;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= EMPTY;
      ptr      <= ID_W'(R - 1);
      out_data <= '0;
      out_id   <= '0;
    end else begin
      state <= state_n;
      if (xfer) begin
        ptr      <= idx;
        out_data <= rot;
        out_id   <= idx;
      end
    end
  end
  assign out_valid = (state == FULL);
  assign busy = out_valid;
endmodule

// File: doc/rotate_arbiter.md
# rotate_arbiter

Round-robin arbiter and sequencer that shares one `param_left_shifter` barrel-rotate datapath among `R` requesters. Each requester presents a word and rotate amount over a valid/ready handshake. The arbiter grants one requester per cycle, rotates its word, and registers the result with the winner's ID behind an output valid/ready stage with backpressure. It sits between the bit-manipulation clients and the single rotator instance, so the datapath is never duplicated.

## Interface
- `N`, 3: rotator select width; data width is `2**N`.
- `R`, 4: number of requesters, at least 2; `ID_W = $clog2(R)`.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in `R`: per-requester request valid.
- `req_ready` out `R`: per-requester accept; one-hot or zero.
- `req_data` in `R x 2**N`: per-requester operand word.
- `req_amt` in `R x N`: per-requester rotate amount.
- `req_dir` in `R`: per-requester direction, 0 = left and 1 = right. Used only with `ROT_ARB_DIR_EN`.
- `out_valid` out 1: result register holds a valid result.
- `out_ready` in 1: downstream accepts the result.
- `out_data` out `2**N`: rotated word.
- `out_id` out `ID_W`: index of the requester that produced `out_data`.
- `busy` out 1: equals `out_valid`.

## Operation
- FSM states:
  - `EMPTY` (reset state): output register invalid.
  - `FULL`: output register valid.
- `can_accept = (state == EMPTY) || out_ready`.
- Grant:
  - Only when `can_accept`.
  - Winner is the first asserted `req_valid` scanning from `ptr+1` upward, modulo `R`.
  - `req_ready[winner] = 1`; all other `req_ready` bits are 0.
  - If no request is valid, or `!can_accept`, `req_ready` is all-zero.
- Handshake:
  - A request transfers when `req_valid[i] && req_ready[i]`.
  - Requesters hold `req_valid`, `req_data`, `req_amt` and `req_dir` stable until accepted.
  - `req_ready` is combinational from `req_valid` and the state. A requester must not gate `req_valid` on `req_ready`.
- Datapath: the winner's data and effective amount are muxed into the single rotator. The rotator output is loaded into `out_data` and the winner index into `out_id`.
- Amount: effective amount = `req_amt`, except with `ROT_ARB_DIR_EN` and `req_dir = 1`, where it is `(-req_amt) mod 2**N` (N-bit two's complement).
  - `amt = 0` passes the word unchanged.
  - No amount is out of range.
- Pointer:
  - `ptr` updates to the winner index only on a transfer.
  - It holds when there is no transfer.
- Transitions:
  - `EMPTY`: transfer goes to `FULL`; otherwise stay.
  - `FULL` with `out_ready` and a transfer: stay `FULL` and load the new result (drain and fill in the same cycle).
  - `FULL` with `out_ready` and no transfer: go to `EMPTY`.
  - `FULL` with `!out_ready`: stay, with all output registers frozen.
- Reset values: `state = EMPTY`, `out_valid = 0`, `out_data = 0`, `out_id = 0`, `ptr = R-1`, so requester 0 has priority first.
- Reset mid-operation: any held result is discarded and not re-issued. Requesters keep their own valid asserted and are re-arbitrated after reset deasserts.

## Timing
- Latency is 1 cycle: a request accepted at edge k shows `out_valid = 1` with its result after edge k.
- Throughput is 1 result per cycle while `out_ready = 1`.
- Fairness: with all `R` requesters continuously valid, each is granted exactly once every `R` transfers.
- Combinational paths:
  - `req_valid` → `req_ready`.
  - `out_ready` → `req_ready`.
  - The rotator and amount negation are between the input mux and the output register, a single cycle.
- `reset` clears all flops asynchronously. Outputs are valid again at the first clock edge after deassertion.

## Configuration
- `ROT_ARB_DIR_EN` defined:
  - `req_dir` is honoured and right-rotate is implemented as a left rotate by the negated amount.
  - Adds one N-bit negate-and-mux in front of the rotator.
- `ROT_ARB_DIR_EN` undefined:
  - `req_dir` is ignored and all rotations are left.
  - The port remains present so the interface is unchanged.

## Structure
- Package `rotate_arb_pkg`:
  - `typedef enum logic {EMPTY, FULL} rot_arb_state_t`.
  - Defaults `ROT_ARB_N_DEF = 3` and `ROT_ARB_R_DEF = 4`.
- Sub-module `rr_picker` (parameter `R`):
  - Inputs: `req`, `ptr`, `en`.
  - Outputs: one-hot `grant` and binary `idx`.
  - Purely combinational.
- The top level holds the FSM, `ptr`, the output registers, the input mux and one `param_left_shifter #(N)` instance.

## Test plan
All cases use N=3 (8-bit), R=4.
- Single request: `req0` with data 8'h81, amt 1 (`out_ready = 1`) → `req_ready = 4'b0001`; next cycle `out_valid = 1`, `out_data = 8'h03`, `out_id = 0`.
- Round-robin: all four valid continuously with `out_ready = 1` → `out_id` sequence 0, 1, 2, 3, 0, 1; `req_ready` is one-hot each cycle.
- Backpressure:
  - `out_ready = 0` for 3 cycles while FULL → `out_data` and `out_id` frozen, `req_ready = 0`.
  - Raise `out_ready` → drain and next accept in the same cycle; no bubble.
- Amount edge cases: data 8'h01 with amt 0 → 8'h01; amt 7 → 8'h80; data 8'hA5 with amt 4 → 8'h5A.
- Direction:
  - With `ROT_ARB_DIR_EN`: data 8'h01, amt 1, dir 1 → 8'h80.
  - Without the macro: the same stimulus → 8'h02.
- Reset mid-operation:
  - Assert `reset` asynchronously while `out_valid = 1` and `ptr = 2` → `out_valid`, `out_data` and `out_id` are 0 immediately.
  - After release with all requesters valid, the first grant goes to requester 0.
